// File: rtl/systemizer_host_pkg.sv
//==============================================================================
// Module      : systemizer_host_pkg
// Description : Shared constants for the systemizer host controller. Holds the
//               matrix geometry, the derived word/address widths and the FSM
//               state encoding used by systemizer_host.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package systemizer_host_pkg;

    // Matrix geometry
    localparam int N     = 4;              // GF(M) elements per memory word
    localparam int M     = 3;              // field size
    localparam int L     = 16;             // matrix rows
    localparam int K     = 24;             // matrix columns

    // Derived widths
    localparam int W     = `CLOG2(M);      // bits per element
    localparam int DW    = N * W;          // bits per memory word
    localparam int DEPTH = L * K / N;      // words in the matrix
    localparam int AW    = `CLOG2(L * K / N);

    // FSM state encoding
    localparam int      STATE_W   = 3;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD   = 3'd1;
    localparam logic [STATE_W-1:0] ST_KICK   = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT   = 3'd3;
    localparam logic [STATE_W-1:0] ST_UNLOAD = 3'd4;
    localparam logic [STATE_W-1:0] ST_DRAIN  = 3'd5;

endpackage

`default_nettype wire

// File: rtl/rd_skid_fifo.sv
//==============================================================================
// Module      : rd_skid_fifo
// Description : Two-entry FIFO catching systemizer read data on the unload
//               path. The caller guarantees no push when full and no pop when
//               empty.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               i_push          - write i_push_data this cycle
//               i_push_data     - entry to store
//               i_pop           - retire the head entry this cycle
//               o_head          - current head entry
//               o_count         - number of stored entries (0..2)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rd_skid_fifo #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/systemizer_host.sv
//==============================================================================
// Module      : systemizer_host
// Description : Host-side controller for the systemizer core. Streams the
//               matrix into systemizer memory, pulses start, waits for
//               done/fail and on success streams the result back out.
// Ports       : clk, rst                 - clock, asynchronous active-high reset
//               go / busy                - job start / job in progress
//               job_done / job_fail      - end-of-job pulse and its status
//               in_valid/in_ready/in_data     - load stream
//               out_valid/out_ready/out_data/out_last - unload stream
//               sys_start/sys_done/sys_fail   - systemizer control
//               sys_wr_en/sys_wr_addr/sys_data_in - systemizer write port
//               sys_rd_en/sys_rd_addr/sys_data_out - systemizer read port
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module systemizer_host
    import systemizer_host_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    output logic          busy,
    output logic          job_done,
    output logic          job_fail,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          sys_start,
    input  logic          sys_done,
    input  logic          sys_fail,
    output logic          sys_wr_en,
    output logic [AW-1:0] sys_wr_addr,
    output logic [DW-1:0] sys_data_in,
    output logic          sys_rd_en,
    output logic [AW-1:0] sys_rd_addr,
    input  logic [DW-1:0] sys_data_out
);

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [AW-1:0]      r_wcnt;
    logic [AW-1:0]      r_rcnt;
    logic               r_wr_en;
    logic [AW-1:0]      r_wr_addr;
    logic [DW-1:0]      r_wr_data;
    logic               r_start;
    logic               r_job_done;
    logic               r_job_fail;
    logic               r_inflight;
    logic               r_rd_last;

    logic               w_in_fire;
    logic               w_pop;
    logic               w_rd_issue;
    logic               w_done_ok;
    logic               w_done_fail;
    logic [2:0]         w_occ;
    logic [1:0]         w_fifo_count;
    logic [DW:0]        w_fifo_head;

    assign in_ready  = (r_state == ST_LOAD);
    assign w_in_fire = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Occupancy counts both stored words and the read whose data returns
    // next cycle; a word leaving this cycle frees its slot for a new read.
    assign w_occ      = {1'b0, w_fifo_count} + {2'b00, r_inflight};
    assign w_rd_issue = (r_state == ST_UNLOAD) && (w_occ < (3'd2 + {2'b00, w_pop}));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and end-of-job decode
    always_comb begin
        w_state_nxt = r_state;
        w_done_ok   = 1'b0;
        w_done_fail = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (go) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_in_fire && (r_wcnt == c_last_addr)) w_state_nxt = ST_KICK;
            end
            ST_KICK: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (sys_done) begin
                    if (sys_fail) begin
                        w_state_nxt = ST_IDLE;
                        w_done_fail = 1'b1;
                    end else begin
                        w_state_nxt = ST_UNLOAD;
                    end
                end
            end
            ST_UNLOAD: begin
                if (w_rd_issue && (r_rcnt == c_last_addr)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((w_fifo_count == 2'd0) && !r_inflight) begin
                    w_state_nxt = ST_IDLE;
                    w_done_ok   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt     <= '0;
            r_rcnt     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_start    <= 1'b0;
            r_job_done <= 1'b0;
            r_job_fail <= 1'b0;
            r_inflight <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_wr_en <= w_in_fire;
            if (w_in_fire) begin
                r_wr_addr <= r_wcnt;
                r_wr_data <= in_data;
            end

            // Counters rest at the terminal value until the job returns to
            // IDLE, so they never wrap inside a job.
            if (r_state == ST_IDLE) begin
                r_wcnt <= '0;
            end else if (w_in_fire && (r_wcnt != c_last_addr)) begin
                r_wcnt <= r_wcnt + AW'(1);
            end

            if (r_state == ST_IDLE) begin
                r_rcnt <= '0;
            end else if (w_rd_issue && (r_rcnt != c_last_addr)) begin
                r_rcnt <= r_rcnt + AW'(1);
            end

            r_start    <= (r_state == ST_KICK);
            r_inflight <= w_rd_issue;
            r_rd_last  <= w_rd_issue && (r_rcnt == c_last_addr);
            r_job_done <= w_done_ok || w_done_fail;
            r_job_fail <= w_done_fail;
        end
    end

    rd_skid_fifo #(
        .WIDTH (DW + 1)
    ) u_rd_skid_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data ({r_rd_last, sys_data_out}),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count)
    );

    assign busy        = (r_state != ST_IDLE);
    assign job_done    = r_job_done;
    assign job_fail    = r_job_fail;
    assign out_valid   = (w_fifo_count != 2'd0);
    assign out_data    = w_fifo_head[DW-1:0];
    assign out_last    = w_fifo_head[DW];
    assign sys_start   = r_start;
    assign sys_wr_en   = r_wr_en;
    assign sys_wr_addr = r_wr_addr;
    assign sys_data_in = r_wr_data;
    assign sys_rd_en   = w_rd_issue;
    assign sys_rd_addr = r_rcnt;

endmodule

`default_nettype wire

// File: tb/tb_systemizer_host.sv
//==============================================================================
// Module      : tb_systemizer_host
// Description : Self-checking bench for systemizer_host with a behavioural
//               systemizer model (fixed done latency, read data addr^0x55).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_systemizer_host;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready = 1'b0;
    logic       sys_done = 1'b0;
    logic       sys_fail = 1'b0;
    logic [7:0] sys_data_out = 8'd0;

    logic       busy, job_done, job_fail, in_ready, out_valid, out_last;
    logic [7:0] out_data, sys_data_in;
    logic       sys_start, sys_wr_en, sys_rd_en;
    logic [6:0] sys_wr_addr, sys_rd_addr;

    always #5 clk = ~clk;

    systemizer_host dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .busy         (busy),
        .job_done     (job_done),
        .job_fail     (job_fail),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .sys_start    (sys_start),
        .sys_done     (sys_done),
        .sys_fail     (sys_fail),
        .sys_wr_en    (sys_wr_en),
        .sys_wr_addr  (sys_wr_addr),
        .sys_data_in  (sys_data_in),
        .sys_rd_en    (sys_rd_en),
        .sys_rd_addr  (sys_rd_addr),
        .sys_data_out (sys_data_out)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Systemizer model: done three cycles after start, read data = addr^0x55
    int model_fail = 0;
    int dly = 0;
    always @(posedge clk) begin
        sys_done <= 1'b0;
        sys_fail <= 1'b0;
        if (sys_rd_en) sys_data_out <= {1'b0, sys_rd_addr} ^ 8'h55;
        if (sys_start) begin
            dly <= 3;
        end else if (dly > 0) begin
            dly <= dly - 1;
            if (dly == 1) begin
                sys_done <= 1'b1;
                sys_fail <= (model_fail != 0);
            end
        end
    end

    // out_ready pattern: 0 = held high, 1 = alternating, 2 = one in three
    int out_pat = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (out_pat)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 2) == 0);
                default: out_ready = ((cyc % 3) == 0);
            endcase
        end
    end

    // Monitor observations, sampled on the falling edge
    int wr_cnt, wr_bad, first_wr, last_wr;
    int start_cnt, start_cyc, sysdone_cyc;
    int rd_cnt, first_rd, issued, popped, max_occ;
    int out_cnt, out_bad, last_cnt, last_bad, first_ov, last_pop, stable_bad;
    int done_cnt, done_fail, done_cyc, busy_at_done;
    logic       prev_hold;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [7:0] exp_word;

    task automatic clear_mon();
        wr_cnt = 0; wr_bad = 0; first_wr = -1; last_wr = -1;
        start_cnt = 0; start_cyc = -1; sysdone_cyc = -1;
        rd_cnt = 0; first_rd = -1; issued = 0; popped = 0; max_occ = 0;
        out_cnt = 0; out_bad = 0; last_cnt = 0; last_bad = 0;
        first_ov = -1; last_pop = -1; stable_bad = 0;
        done_cnt = 0; done_fail = -1; done_cyc = -1; busy_at_done = -1;
        prev_hold = 1'b0; prev_data = 8'd0; prev_last = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sys_wr_en) begin
            if (wr_cnt == 0) first_wr = cyc;
            last_wr = cyc;
            if (int'(sys_wr_addr) != wr_cnt || int'(sys_data_in) != wr_cnt) wr_bad++;
            wr_cnt++;
        end
        if (sys_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (sys_done) sysdone_cyc = cyc;
        if (sys_rd_en) begin
            if (rd_cnt == 0) first_rd = cyc;
            rd_cnt++;
            issued++;
        end
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (prev_hold && (!out_valid || out_data != prev_data || out_last != prev_last))
            stable_bad++;
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
        if (out_valid && out_ready) begin
            exp_word = 8'(out_cnt) ^ 8'h55;
            if (out_data != exp_word) out_bad++;
            if (out_last) begin
                last_cnt++;
                if (out_cnt != 95) last_bad++;
            end
            out_cnt++;
            popped++;
            last_pop = cyc;
        end
        if (issued - popped > max_occ) max_occ = issued - popped;
        if (job_done) begin
            done_cnt++;
            done_fail = int'(job_fail);
            done_cyc = cyc;
            busy_at_done = int'(busy);
        end
    end

    typedef struct {
        int fail;      // model reports fail
        int in_pat;    // 0 = in_valid held high, 1 = pattern 1,0,0,1
        int opat;      // out_ready pattern
        int exp_fail;  // expected job_fail
        int exp_words; // expected reads issued and words unloaded
    } job_t;

    job_t jobs[4];

    task automatic run_job(input int j);
        int sent;
        int g;
        int last_acc;
        string p;
        p = $sformatf("job%0d", j);
        clear_mon();
        model_fail = jobs[j].fail;
        out_pat    = jobs[j].opat;
        last_acc   = -1;

        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        @(negedge clk);
        check({p, "_in_ready_after_go"}, int'(in_ready), 1);
        @(posedge clk); #1;

        sent = 0;
        g = 0;
        while (sent < 96 && g < 1000) begin
            in_valid = (jobs[j].in_pat == 0) ? 1'b1 : ((g % 4 == 0) || (g % 4 == 3));
            in_data  = 8'(sent);
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                if (sent == 96) last_acc = cyc;
            end
            @(posedge clk); #1;
            g++;
        end
        in_valid = 1'b0;
        check({p, "_words_accepted"}, sent, 96);

        // A go pulse while waiting for the systemizer must be ignored
        g = 0;
        while (start_cnt == 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;

        g = 0;
        while (done_cnt == 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);

        check({p, "_wr_count"}, wr_cnt, 96);
        check({p, "_wr_addr_data"}, wr_bad, 0);
        check({p, "_last_wr_lat"}, last_wr - last_acc, 1);
        check({p, "_start_pulses"}, start_cnt, 1);
        check({p, "_start_lat"}, start_cyc - last_acc, 2);
        check({p, "_done_pulses"}, done_cnt, 1);
        check({p, "_job_fail"}, done_fail, jobs[j].exp_fail);
        check({p, "_busy_at_done"}, busy_at_done, 0);
        check({p, "_busy_after"}, int'(busy), 0);
        check({p, "_reads"}, rd_cnt, jobs[j].exp_words);
        check({p, "_out_words"}, out_cnt, jobs[j].exp_words);
        check({p, "_out_data"}, out_bad, 0);
        check({p, "_last_count"}, last_cnt, (jobs[j].exp_words > 0) ? 1 : 0);
        check({p, "_last_pos"}, last_bad, 0);
        check({p, "_occ_le2"}, int'(max_occ <= 2), 1);
        check({p, "_hold_stable"}, stable_bad, 0);
        if (jobs[j].in_pat == 0)
            check({p, "_wr_back_to_back"}, last_wr - first_wr, 95);
        if (jobs[j].fail != 0) begin
            check({p, "_fail_done_lat"}, done_cyc - sysdone_cyc, 1);
        end else begin
            check({p, "_first_rd_lat"}, first_rd - sysdone_cyc, 1);
            check({p, "_first_ov_lat"}, first_ov - first_rd, 2);
            check({p, "_done_after_pop"}, done_cyc - last_pop, 2);
            if (jobs[j].opat == 0)
                check({p, "_full_rate_span"}, last_pop - first_ov, 95);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        jobs[0] = '{0, 0, 0, 0, 96};
        jobs[1] = '{1, 1, 0, 1, 0};
        jobs[2] = '{0, 1, 1, 0, 96};
        jobs[3] = '{0, 0, 2, 0, 96};
        clear_mon();

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", int'({busy, in_ready, out_valid, out_last, job_done,
                                job_fail, sys_start, sys_wr_en, sys_rd_en}), 0);
        check("rst_bus", int'({sys_wr_addr, sys_data_in, sys_rd_addr, out_data}), 0);
        @(negedge clk) rst = 1'b0;

        // go latency, then reset in the middle of a load
        @(posedge clk); #1 go = 1'b1;
        @(negedge clk);
        check("go_cycle_in_ready", int'(in_ready), 0);
        @(posedge clk); #1 go = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd0;
        @(negedge clk);
        check("go_next_in_ready", int'(in_ready), 1);
        repeat (10) begin
            @(posedge clk); #1 in_data = in_data + 8'd1;
        end
        #1 rst = 1'b1;
        #1;
        check("midjob_rst_ctrl", int'({busy, in_ready, out_valid, job_done,
                                       sys_start, sys_wr_en, sys_rd_en}), 0);
        check("midjob_rst_wr_addr", int'(sys_wr_addr), 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midjob_rst_no_done", done_cnt, 0);

        for (int j = 0; j < 4; j++) run_job(j);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
